// File: rtl/data_mem_responder_pkg.sv
// Shared memory map for the data-port responder: MMIO base, register offsets,
// status bit positions and the address-region decoder.
package data_mem_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

  // Word offsets inside the MMIO window (address[7:2]).
  localparam logic [5:0] OFF_CONSOLE = 6'h00;
  localparam logic [5:0] OFF_STATUS  = 6'h01;
  localparam logic [5:0] OFF_CYCLE   = 6'h02;
  localparam logic [5:0] OFF_COUNT   = 6'h03;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_MMIO = 2'd1,
    RGN_NONE = 2'd2
  } region_t;

  // ram_bits is the byte-address width of the RAM region (log2(words) + 2).
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned ram_bits);
    if ((addr >> ram_bits) == 32'd0)
      return RGN_RAM;
    else if (addr[31:8] == base[31:8])
      return RGN_MMIO;
    else
      return RGN_NONE;
  endfunction

endpackage

// File: rtl/data_mem_responder_console_fifo.sv
// Console TX FIFO: count-based full/empty, power-of-two depth, head byte
// presented straight from the storage array.
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop_fire;
  logic             push_fire;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
  assign pop_fire  = !reset && pop && !empty;
  assign push_fire = !reset && push && (!full || pop_fire);

  always_ff @(posedge clk) begin
    if (push_fire)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_fire)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM with combinational read, MMIO console FIFO,
// status/count registers, free-running cycle counter and unmapped-write flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        err_unmapped
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  region_t       region;
  logic [5:0]    offset;
  logic          mmio_we;
  logic          wr_console;
  logic          wr_status;
  logic          wr_cycle;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          pop_fire;
  logic          overflow_reg;
  logic          err_reg;
  logic [31:0]   cycle_reg;

  assign region  = decode_region(address_to_mem, MMIO_BASE, AW + 2);
  assign ram_idx = address_to_mem[AW+1:2];
  assign offset  = address_to_mem[7:2];

  assign mmio_we    = WE && (region == RGN_MMIO);
  assign wr_console = mmio_we && (offset == OFF_CONSOLE);
  assign wr_status  = mmio_we && (offset == OFF_STATUS);
  assign wr_cycle   = mmio_we && (offset == OFF_CYCLE);
  assign pop_fire   = cons_ready && !fifo_empty;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_console),
    .din   (data_to_mem[7:0]),
    .pop   (cons_ready),
    .dout  (cons_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign cons_valid   = !fifo_empty;
  assign err_unmapped = err_reg;

  // RAM contents survive reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && WE && (region == RGN_RAM))
      ram[ram_idx] <= data_to_mem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      err_reg      <= 1'b0;
      cycle_reg    <= 32'd0;
    end else begin
      if (wr_console && fifo_full && !pop_fire)
        overflow_reg <= 1'b1;
      else if (wr_status && data_to_mem[ST_OVF])
        overflow_reg <= 1'b0;

      if (WE && (region == RGN_NONE))
        err_reg <= 1'b1;

      if (wr_cycle)
        cycle_reg <= data_to_mem;
      else
        cycle_reg <= cycle_reg + 32'd1;
    end
  end

  always_comb begin
    data_from_mem = 32'd0;
    case (region)
      RGN_RAM: data_from_mem = ram[ram_idx];
      RGN_MMIO: begin
        case (offset)
          OFF_STATUS: begin
            data_from_mem[ST_EMPTY] = fifo_empty;
            data_from_mem[ST_FULL]  = fifo_full;
            data_from_mem[ST_OVF]   = overflow_reg;
          end
          OFF_CYCLE: data_from_mem = cycle_reg;
          OFF_COUNT: data_from_mem = {{(32-CW){1'b0}}, fifo_count};
          default:   data_from_mem = 32'd0;
        endcase
      end
      default: data_from_mem = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table for RAM/MMIO reads and writes,
// hand-written sequences for FIFO, overflow, unmapped and reset corner cases.
module tb_data_mem_responder;

  localparam logic [31:0] A_CONS   = 32'hFFFF_FF00;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF04;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF08;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_FF0C;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic        err_unmapped;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] rd_q [$];
  logic [7:0]  byte_q [$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .WE             (WE),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem),
    .cons_valid     (cons_valid),
    .cons_data      (cons_data),
    .cons_ready     (cons_ready),
    .err_unmapped   (err_unmapped)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    WE = we;
    address_to_mem = a;
    data_to_mem = d;
    cons_ready = rdy;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    drive(1'b1, a, d, rdy);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, a, 32'd0, 1'b0);
    rd_q.push_back(exp);
    check(nm, data_from_mem, rd_q.pop_front());
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr(A_CONS, {24'd0, b}, 1'b0);
    byte_q.push_back(b);
  endtask

  // Pops every expected byte, one per cycle, then confirms the FIFO is empty.
  task automatic drain(input string nm);
    while (byte_q.size() > 0) begin
      drive(1'b0, A_STATUS, 32'd0, 1'b1);
      check({nm, " valid"}, {31'd0, cons_valid}, 32'd1);
      check({nm, " data"}, {24'd0, cons_data}, {24'd0, byte_q.pop_front()});
    end
    drive(1'b0, A_STATUS, 32'd0, 1'b0);
    check({nm, " empty"}, {31'd0, cons_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    WE = 1'b0;
    address_to_mem = 32'd0;
    data_to_mem = 32'd0;
    cons_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    @(negedge clk);
    reset = 1'b0;
    address_to_mem = A_CYCLE;
    #1;
    check("reset cycle", data_from_mem, 32'd0);
    check("reset cons_valid", {31'd0, cons_valid}, 32'd0);
    check("reset err", {31'd0, err_unmapped}, 32'd0);
    rd("cycle +1", A_CYCLE, 32'd1);
    rd("reset status", A_STATUS, 32'd1);
    rd("reset count", A_COUNT, 32'd0);

    tbl.push_back('{1'b1, 32'h0000_0010, 32'hCAFE_BABE, 1'b0, 32'd0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'd0, 1'b1, 32'hCAFE_BABE});
    tbl.push_back('{1'b0, 32'h0000_0013, 32'd0, 1'b1, 32'hCAFE_BABE});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'd0});
    tbl.push_back('{1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b0, 32'd0});
    tbl.push_back('{1'b0, 32'h0000_0FFC, 32'd0, 1'b1, 32'h1234_5678});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'd0, 1'b1, 32'h1111_1111});
    tbl.push_back('{1'b0, 32'h0000_1000, 32'd0, 1'b1, 32'd0});
    tbl.push_back('{1'b0, A_CONS, 32'd0, 1'b1, 32'd0});
    tbl.push_back('{1'b1, 32'hFFFF_FF10, 32'h5, 1'b0, 32'd0});
    tbl.push_back('{1'b0, 32'hFFFF_FF10, 32'd0, 1'b1, 32'd0});
    tbl.push_back('{1'b1, A_COUNT, 32'h7, 1'b0, 32'd0});
    tbl.push_back('{1'b0, A_COUNT, 32'd0, 1'b1, 32'd0});
    tbl.push_back('{1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0, 32'd0});
    tbl.push_back('{1'b0, A_CYCLE, 32'd0, 1'b1, 32'hFFFF_FFFE});
    tbl.push_back('{1'b0, A_CYCLE, 32'd0, 1'b1, 32'hFFFF_FFFF});
    tbl.push_back('{1'b0, A_CYCLE, 32'd0, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b0, A_CYCLE, 32'd0, 1'b1, 32'h0000_0001});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].data, 1'b0);
      if (tbl[i].chk) begin
        rd_q.push_back(tbl[i].exp);
        check($sformatf("vec%0d rd 0x%08h", i, tbl[i].addr), data_from_mem, rd_q.pop_front());
      end
    end
    rd("mapped writes no err", A_STATUS, 32'd1);
    check("err after table", {31'd0, err_unmapped}, 32'd0);

    // Console: three bytes, held, then drained
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    rd("abc count", A_COUNT, 32'd3);
    check("abc head", {24'd0, cons_data}, 32'h41);
    drain("abc");
    rd("abc status empty", A_STATUS, 32'd1);

    // Fill, overflow, clear, push during pop while full
    for (int i = 0; i < 8; i++) push_byte(8'h60 + 8'(i));
    rd("full status", A_STATUS, 32'd2);
    wr(A_CONS, 32'h69, 1'b0);
    rd("ovf status", A_STATUS, 32'd6);
    rd("ovf count", A_COUNT, 32'd8);
    wr(A_STATUS, 32'h4, 1'b0);
    rd("ovf cleared", A_STATUS, 32'd2);
    wr(A_CONS, 32'h6A, 1'b1);
    check("full push+pop head", {24'd0, cons_data}, {24'd0, byte_q.pop_front()});
    byte_q.push_back(8'h6A);
    rd("full push+pop count", A_COUNT, 32'd8);
    rd("full push+pop no ovf", A_STATUS, 32'd2);
    drain("full");

    // Push with ready=1 into an empty FIFO
    wr(A_CONS, 32'h55, 1'b1);
    check("empty push+pop valid", {31'd0, cons_valid}, 32'd0);
    byte_q.push_back(8'h55);
    rd("empty push+pop count", A_COUNT, 32'd1);
    drain("single");

    // Unmapped write
    wr(32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
    rd("unmapped read", 32'h8000_0000, 32'd0);
    check("err set", {31'd0, err_unmapped}, 32'd1);
    rd("ram idx0 untouched", 32'h0000_0000, 32'h1111_1111);
    rd("ram 0x10 untouched", 32'h0000_0010, 32'hCAFE_BABE);
    rd("status after unmapped", A_STATUS, 32'd1);
    check("err sticky", {31'd0, err_unmapped}, 32'd1);

    // Reset mid-traffic with a RAM write pending
    for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i));
    rd("pre-reset count", A_COUNT, 32'd5);
    @(negedge clk);
    reset = 1'b1;
    WE = 1'b1;
    address_to_mem = 32'h0000_0010;
    data_to_mem = 32'hBAD0_BAD0;
    cons_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    WE = 1'b0;
    cons_ready = 1'b0;
    address_to_mem = A_CYCLE;
    #1;
    byte_q.delete();
    check("post-reset cycle", data_from_mem, 32'd0);
    check("post-reset valid", {31'd0, cons_valid}, 32'd0);
    check("post-reset err", {31'd0, err_unmapped}, 32'd0);
    rd("post-reset count", A_COUNT, 32'd0);
    rd("post-reset ram", 32'h0000_0010, 32'hCAFE_BABE);
    rd("post-reset cycle+3", A_CYCLE, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
